// File: rtl/mem_ctrl.sv
// Shares one byte-wide RAM port between instruction fetch and load/store, assembling words little-endian.
// Reads finish N+1 cycles after grant and writes N cycles after; requesters hold their request until the done pulse, and flush aborts a fetch.
module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        flush,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [1:0]  mem_size,
  input  logic [31:0] mem_wdata,
  input  logic [7:0]  ram_din,
  output logic [31:0] if_data,
  output logic        if_done,
  output logic [31:0] mem_rdata,
  output logic        mem_done,
  output logic [31:0] ram_addr,
  output logic [7:0]  ram_dout,
  output logic        ram_wr,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, IF_RD, MEM_RD, MEM_WR} state_t;

  state_t      state;
  logic [2:0]  cnt;
  logic [2:0]  last;
  logic [31:0] acc;
  logic [31:0] wbuf;
  logic [31:0] acc_nxt;

  function automatic logic [2:0] size_last(input logic [1:0] s);
    case (s)
      2'b00:   return 3'd0;
      2'b01:   return 3'd1;
      default: return 3'd3;
    endcase
  endfunction

  always_comb begin
    acc_nxt = acc;
    acc_nxt[{cnt[1:0], 3'b000} +: 8] = ram_din;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      last      <= '0;
      acc       <= '0;
      wbuf      <= '0;
      if_data   <= '0;
      if_done   <= 1'b0;
      mem_rdata <= '0;
      mem_done  <= 1'b0;
      ram_addr  <= '0;
      ram_dout  <= '0;
      ram_wr    <= 1'b0;
    end else begin
      if_done  <= 1'b0;
      mem_done <= 1'b0;
      case (state)
        IDLE: begin
          // A requester still sees its done pulse this cycle, so its level request is stale.
          if (!if_done && !mem_done) begin
            if (mem_req) begin
              cnt      <= '0;
              acc      <= '0;
              ram_addr <= mem_addr;
              last     <= size_last(mem_size);
              if (mem_we) begin
                state    <= MEM_WR;
                ram_wr   <= 1'b1;
                ram_dout <= mem_wdata[7:0];
                wbuf     <= mem_wdata >> 8;
                mem_done <= (size_last(mem_size) == 3'd0);
              end else begin
                state <= MEM_RD;
              end
            end else if (if_req && !flush) begin
              state    <= IF_RD;
              cnt      <= '0;
              acc      <= '0;
              ram_addr <= if_addr;
              last     <= 3'd3;
            end
          end
        end
        IF_RD, MEM_RD: begin
          if (state == IF_RD && flush) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            acc <= acc_nxt;
            if (cnt == last) begin
              state <= IDLE;
              cnt   <= '0;
              if (state == IF_RD) begin
                if_done <= 1'b1;
                if_data <= acc_nxt;
              end else begin
                mem_done  <= 1'b1;
                mem_rdata <= acc_nxt;
              end
            end else begin
              cnt      <= cnt + 3'd1;
              ram_addr <= ram_addr + 32'd1;
            end
          end
        end
        MEM_WR: begin
          if (cnt == last) begin
            state  <= IDLE;
            cnt    <= '0;
            ram_wr <= 1'b0;
          end else begin
            // Done goes out alongside the final byte, not after it.
            cnt      <= cnt + 3'd1;
            ram_addr <= ram_addr + 32'd1;
            ram_dout <= wbuf[7:0];
            wbuf     <= wbuf >> 8;
            mem_done <= ((cnt + 3'd1) == last);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  synchronous reset, active-low (rst==0 sampled at a rising edge resets).
REQ-003 if_req  in  1  IF stage fetch request; level, held until if_done or flush.
REQ-004 if_addr  in  32  fetch byte address; word fetch, 4 bytes.
REQ-005 flush  in  1  branch taken from EX; aborts outstanding/pending fetch.
REQ-006 mem_req  in  1  MEM stage access request; level, held until mem_done.
REQ-007 mem_we  in  1  1=store, 0=load.
REQ-008 mem_addr  in  32  load/store byte address.
REQ-009 mem_size  in  2  00=byte, 01=half, 10=word; 11 treated as word.
REQ-010 mem_wdata  in  32  store data; low N bytes used.
REQ-011 ram_din  in  8  RAM read byte for address driven in previous cycle.
REQ-012 if_data  out  32  fetched instruction; valid only while if_done=1.
REQ-013 if_done  out  1  one-cycle pulse, fetch complete.
REQ-014 mem_rdata  out  32  load data, zero-extended; valid only while mem_done=1.
REQ-015 mem_done  out  1  one-cycle pulse, load/store complete.
REQ-016 ram_addr  out  32  RAM byte address (registered).
REQ-017 ram_dout  out  8  RAM write byte (registered).
REQ-018 ram_wr  out  1  1=write ram_dout to ram_addr at next edge (registered).
REQ-019 busy  out  1  1 whenever state != IDLE.

Function
REQ-020 FSM states SHALL be IDLE, IF_RD, MEM_RD, MEM_WR, plus a 3-bit byte counter.
REQ-021 Arbitration in IDLE: mem_req SHALL win over if_req (older instruction); if_req granted only when mem_req=0 and flush=0.
REQ-022 Grant edge E0: state<=IF_RD/MEM_RD/MEM_WR, ram_addr<=base address, counter<=0; N=4 for IF, N=1/2/4 per mem_size.
REQ-023 Read: ram_addr SHALL be base+k during cycle after edge E0+k, k=0..N-1; ram_din sampled at edge E0+k+1 is byte k.
REQ-024 Read assembly little-endian: byte k -> bits [8k+7:8k]; unused upper bits 0.
REQ-025 Read completion: at edge E0+N, done pulse and data registered, state<=IDLE; done high exactly one cycle.
REQ-026 Write: ram_wr=1, ram_addr=base+k, ram_dout=mem_wdata[8k+7:8k] during cycle after edge E0+k, k=0..N-1; mem_done pulse in cycle after edge E0+N-1 with ram_wr=0 from edge E0+N.
REQ-027 ram_wr SHALL be 0 in every state other than MEM_WR.
REQ-028 Requests SHALL be ignored in the cycle done is high; earliest next grant is the following edge.
REQ-029 flush=1 at any edge in IF_RD: state<=IDLE, counter<=0, no if_done for that fetch; flush in IDLE suppresses IF grant that edge.
REQ-030 flush SHALL NOT affect MEM_RD/MEM_WR; a pending mem_req MAY be granted on the edge flush aborts IF_RD? No: granted at the next edge from IDLE.
REQ-031 Address increment SHALL wrap modulo 2^32.
REQ-032 Inputs addr/size/wdata SHALL be latched at grant; changes mid-transaction ignored.

Reset
REQ-033 rst==0 at an edge: state<=IDLE, counter<=0, all outputs <=0, regardless of current state.
REQ-034 Reset mid-transaction SHALL abort with no done pulse; ram_wr=0 from the cycle after the reset edge.

Verification
REQ-035 IF fetch 0x00000100, RAM bytes 13,05,50,00 -> ram_addr 0x100..0x103 in order, if_done at E0+4, if_data=0x00500513.
REQ-036 if_req and mem_req(load word 0x200) high same cycle -> MEM_RD first, mem_done; IF granted edge after mem_done cycle; no overlap.
REQ-037 Store byte, mem_wdata=0x123456AB, addr 0x30004 -> single ram_wr cycle, ram_addr=0x30004, ram_dout=0xAB, then mem_done, busy drops.
REQ-038 Load half at 0x2, RAM bytes FE,FF -> mem_rdata=0x0000FFFE, mem_done at E0+2.
REQ-039 flush at E0+2 of fetch -> no if_done, IDLE next cycle, subsequent mem_req granted normally.
REQ-040 rst=0 at E0+2 of store word -> ram_wr=0, busy=0 next cycle, no mem_done; IF fetch after reset completes normally.
